// File: rtl/prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_queue_pkg
//
// Shared core definitions for the fetch stage of the ARM7TDMI-compatible core.
//   - proc_mode_e   : processor mode encodings (CPSR[4:0]), USER .. SYSTEM
//   - isa_e         : instruction set state (ARM / Thumb), mirrors CPSR.T
//   - RESET_VECTOR_DEFAULT : default first fetch address after reset
//   - ARM/Thumb instruction width and byte-size constants
// -----------------------------------------------------------------------------
package prefetch_queue_pkg;

  typedef enum logic [4:0] {
    MODE_USER       = 5'b10000,
    MODE_FIQ        = 5'b10001,
    MODE_IRQ        = 5'b10010,
    MODE_SUPERVISOR = 5'b10011,
    MODE_ABORT      = 5'b10111,
    MODE_UNDEFINED  = 5'b11011,
    MODE_SYSTEM     = 5'b11111
  } proc_mode_e;

  typedef enum logic {
    ISA_ARM   = 1'b0,
    ISA_THUMB = 1'b1
  } isa_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam int ARM_INSTR_WIDTH   = 32;
  localparam int THUMB_INSTR_WIDTH = 16;
  localparam int ARM_INSTR_BYTES   = ARM_INSTR_WIDTH / 8;
  localparam int THUMB_INSTR_BYTES = THUMB_INSTR_WIDTH / 8;

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
//
// Synchronous FIFO holding {address, word} pairs for the prefetch queue.
// Clear has priority over push and pop. Push while full and pop while empty
// are ignored. The head entry is presented combinationally on rdata.
//
// Ports:
//   mclk   in            : clock, rising edge
//   reset  in            : asynchronous active-high reset (pointers, count)
//   clear  in            : drop all entries this cycle
//   push   in            : write wdata at the tail
//   wdata  in  [WIDTH]   : entry to write
//   pop    in            : retire the head entry
//   rdata  out [WIDTH]   : head entry (undefined while empty)
//   count  out [CW]      : number of stored entries, 0..DEPTH
//   full   out           : count == DEPTH
//   empty  out           : count == 0
// -----------------------------------------------------------------------------
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count and
  // the pointers, so resetting the data would only cost flops and routing.
  always_ff @(posedge mclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch buffer for the fetch stage. Issues sequential word
// fetches, holds them through nWAIT stalls, queues {addr, word} pairs and
// hands ARM words or Thumb halfwords to decode over a valid/ready handshake.
// A flush discards the queue and restarts fetching at a branch target.
//
// Ports:
//   mclk          in                : clock, rising edge
//   reset         in                : asynchronous active-high reset
//   tbit          in                : Thumb state, captured only on flush
//   flush         in                : discard queue, redirect to flush_target
//   flush_target  in  [ADDR_WIDTH]  : new PC
//   mem_req       out               : fetch request this cycle
//   mem_addr      out [ADDR_WIDTH]  : word-aligned fetch address
//   mem_seq       out               : request follows the previous fetch
//   nWAIT         in                : 0 = memory stalls the current access
//   mem_rdata     in  [DATA_WIDTH]  : fetch data, valid when mem_req & nWAIT
//   dec_valid     out               : an instruction is presented to decode
//   dec_ready     in                : decode accepts the instruction
//   dec_instr     out [DATA_WIDTH]  : ARM word or zero-extended Thumb halfword
//   dec_pc        out [ADDR_WIDTH]  : address of dec_instr
//   occupancy     out [clog2(D+1)]  : number of queued words
// -----------------------------------------------------------------------------
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEFAULT),
  localparam int                   CW           = $clog2(DEPTH + 1)
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  tbit,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_seq,
  input  logic                  nWAIT,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [CW-1:0]         occupancy
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = THUMB_INSTR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  seq_r;
  logic                  hsel;
  isa_e                  thumb_r;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_word;
  logic [TW-1:0]         head_half;

  logic                  fetch_done;
  logic                  consume;
  logic                  pop;

  // Bit 0 of a branch target never selects anything: ARM targets are word
  // aligned and Thumb targets halfword aligned.
  logic                  unused_target_lsb;
  assign unused_target_lsb = flush_target[0];

  // ---------------------------------------------------------------------------
  // Memory side
  // ---------------------------------------------------------------------------
  // Requests stop while the queue is full even if decode pops this cycle; the
  // one-cycle bubble keeps mem_req free of any path from dec_ready. The reset
  // term forces mem_req low while reset is held, before any edge occurs.
  assign mem_req    = !reset && !flush && !fifo_full;
  assign mem_addr   = fetch_addr;
  assign mem_seq    = seq_r;
  assign fetch_done = mem_req && nWAIT;

  // ---------------------------------------------------------------------------
  // Decode side
  // ---------------------------------------------------------------------------
  assign dec_valid = !fifo_empty;
  assign consume   = dec_valid && dec_ready && !flush;
  // In Thumb state a word is retired only after its upper halfword is taken.
  assign pop       = consume && ((thumb_r == ISA_ARM) || hsel);

  assign head_addr = fifo_head[EW-1 -: ADDR_WIDTH];
  assign head_word = fifo_head[DATA_WIDTH-1:0];
  assign head_half = hsel ? head_word[2*TW-1 -: TW] : head_word[TW-1:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    dec_instr = head_word;
    dec_pc    = head_addr;
    if (thumb_r == ISA_THUMB) begin
      dec_instr = DATA_WIDTH'(head_half);
      dec_pc    = head_addr + ADDR_WIDTH'({hsel, 1'b0});
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch address, sequencing, ISA state and halfword select
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      fetch_addr <= {RESET_VECTOR[ADDR_WIDTH-1:2], 2'b00};
      seq_r      <= 1'b0;
      hsel       <= 1'b0;
      thumb_r    <= ISA_ARM;
    end else if (flush) begin
      fetch_addr <= {flush_target[ADDR_WIDTH-1:2], 2'b00};
      seq_r      <= 1'b0;
      thumb_r    <= isa_e'(tbit);
      hsel       <= tbit && flush_target[1];
    end else begin
      if (fetch_done) begin
        // Wraps modulo 2^ADDR_WIDTH; the fetch stream stays sequential.
        fetch_addr <= fetch_addr + ADDR_WIDTH'(ARM_INSTR_BYTES);
        seq_r      <= 1'b1;
      end
      if (consume && (thumb_r == ISA_THUMB)) begin
        hsel <= !hsel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word queue; a flush clears it and drops any data returned that cycle.
  // ---------------------------------------------------------------------------
  prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .mclk  (mclk),
    .reset (reset),
    .clear (flush),
    .push  (fetch_done),
    .wdata ({fetch_addr, mem_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
